rx_frame_filter: RTL

- Receive-side address filter between the MAC Rx stream and the Rx descriptor/data DMA stage.
- Holds each frame's destination address (DA) and checks it against broadcast, unicast promiscuous, multicast promiscuous, the 16-entry receive address table and the 4096-bit multicast hash table.
- Accepted frames go downstream unchanged. Rejected and runt frames are consumed and discarded.
- Flags frames longer than the size limit set by LPE.

---
 rtl/rx_frame_filter.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/rx_frame_filter.sv
// Rx destination-address filter: holds the 8-byte header, matches the DA against
// broadcast, promiscuous, address-table and multicast-hash rules, then replays or discards.
module rx_frame_filter #(
    parameter int MAX_STD_LEN  = 1522,
    parameter int MAX_LONG_LEN = 16384
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        EN,
    input  logic        UPE,
    input  logic        MPE,
    input  logic        BAM,
    input  logic        LPE,
    input  logic [1:0]  MO,
    output logic [3:0]  rtbl_index,
    input  logic [63:0] rtbl_data,
    output logic [6:0]  mtbl_index,
    input  logic [31:0] mtbl_data,
    input  logic [31:0] mac_s_tdata,
    input  logic [3:0]  mac_s_tkeep,
    input  logic        mac_s_tvalid,
    input  logic        mac_s_tlast,
    output logic        mac_s_tready,
    output logic [31:0] out_m_tdata,
    output logic [3:0]  out_m_tkeep,
    output logic        out_m_tvalid,
    output logic        out_m_tlast,
    output logic        out_m_tuser,
    input  logic        out_m_tready,
    output logic [15:0] frames_ok,
    output logic [15:0] frames_drop
);

    typedef enum logic [2:0] {
        S_IDLE, S_HDR1, S_LOOKUP, S_DECIDE, S_REPLAY, S_FWD, S_DROP
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] w0_q, w0_d, w1_q, w1_d;
    logic        en_q, en_d, lpe_q, lpe_d;
    logic        run_q, run_d;
    logic [6:0]  mtbl_index_q, mtbl_index_d;
    logic [4:0]  hbit_q, hbit_d;
    logic [4:0]  lk_cnt_q, lk_cnt_d;
    logic        match_q, match_d;
    logic        rp_q, rp_d;
    logic [15:0] bytes_q, bytes_d;
    logic [15:0] ok_q, ok_d, drop_q, drop_d;

    logic [47:0] da;
    logic        bcast, mcast, accept;
    logic [11:0] hash;
    logic [16:0] sum17, limit;
    logic [15:0] bytes_sum;
    logic        ok_inc, drop_inc;
    logic        unused_rtbl;

    assign unused_rtbl = ^rtbl_data[62:48];
    assign da          = {w1_q[15:0], w0_q};
    assign bcast       = &da;
    assign mcast       = da[0] && !bcast;
    assign accept      = en_q && (bcast ? BAM :
                                  mcast ? (MPE || mtbl_data[hbit_q] || match_q) :
                                          (UPE || match_q));
    assign limit       = lpe_q ? 17'(MAX_LONG_LEN) : 17'(MAX_STD_LEN);
    assign rtbl_index  = (state_q == S_LOOKUP) ? lk_cnt_q[3:0] : 4'd0;
    assign mtbl_index  = mtbl_index_q;
    assign frames_ok   = ok_q;
    assign frames_drop = drop_q;

    function automatic logic [2:0] popcnt(input logic [3:0] k);
        popcnt = 3'(k[0]) + 3'(k[1]) + 3'(k[2]) + 3'(k[3]);
    endfunction

    // Hash bits come from DA bytes d4/d5, which sit in the low half of the second beat.
    always_comb begin
        case (MO)
            2'd0:    hash = mac_s_tdata[15:4];
            2'd1:    hash = mac_s_tdata[14:3];
            2'd2:    hash = mac_s_tdata[13:2];
            default: hash = mac_s_tdata[11:0];
        endcase
    end

    assign sum17     = {1'b0, bytes_q} + 17'(popcnt(mac_s_tkeep));
    assign bytes_sum = sum17[16] ? 16'hFFFF : sum17[15:0];

    always_comb begin
        state_d      = state_q;
        w0_d         = w0_q;
        w1_d         = w1_q;
        en_d         = en_q;
        lpe_d        = lpe_q;
        run_d        = 1'b1;
        mtbl_index_d = mtbl_index_q;
        hbit_d       = hbit_q;
        lk_cnt_d     = lk_cnt_q;
        match_d      = match_q;
        rp_d         = rp_q;
        bytes_d      = bytes_q;
        ok_inc       = 1'b0;
        drop_inc     = 1'b0;
        mac_s_tready = 1'b0;
        out_m_tvalid = 1'b0;
        out_m_tdata  = mac_s_tdata;
        out_m_tkeep  = mac_s_tkeep;
        out_m_tlast  = 1'b0;
        out_m_tuser  = 1'b0;

        case (state_q)
            S_IDLE: begin
                // run_q keeps ready low while the block sits in reset
                mac_s_tready = run_q;
                if (run_q && mac_s_tvalid) begin
                    w0_d = mac_s_tdata;
                    en_d = EN;
                    if (mac_s_tlast) drop_inc = 1'b1;
                    else             state_d  = S_HDR1;
                end
            end
            S_HDR1: begin
                mac_s_tready = 1'b1;
                if (mac_s_tvalid) begin
                    w1_d         = mac_s_tdata;
                    mtbl_index_d = hash[11:5];
                    hbit_d       = hash[4:0];
                    if (mac_s_tlast) begin
                        drop_inc = 1'b1;
                        state_d  = S_IDLE;
                    end else begin
                        lk_cnt_d = 5'd0;
                        match_d  = 1'b0;
                        state_d  = S_LOOKUP;
                    end
                end
            end
            S_LOOKUP: begin
                // entry (lk_cnt_q-1) arrives this cycle; 17 cycles covers all 16
                if (lk_cnt_q != 5'd0 && rtbl_data[63] && rtbl_data[47:0] == da)
                    match_d = 1'b1;
                if (lk_cnt_q == 5'd16) state_d  = S_DECIDE;
                else                   lk_cnt_d = lk_cnt_q + 5'd1;
            end
            S_DECIDE: begin
                lpe_d   = LPE;
                bytes_d = 16'd8;
                rp_d    = 1'b0;
                state_d = accept ? S_REPLAY : S_DROP;
            end
            S_REPLAY: begin
                out_m_tvalid = 1'b1;
                out_m_tdata  = rp_q ? w1_q : w0_q;
                out_m_tkeep  = 4'hF;
                if (out_m_tready) begin
                    if (rp_q) state_d = S_FWD;
                    else      rp_d    = 1'b1;
                end
            end
            S_FWD: begin
                mac_s_tready = out_m_tready;
                out_m_tvalid = mac_s_tvalid;
                out_m_tlast  = mac_s_tlast;
                out_m_tuser  = mac_s_tlast && ({1'b0, bytes_sum} > limit);
                if (mac_s_tvalid && out_m_tready) begin
                    bytes_d = bytes_sum;
                    if (mac_s_tlast) begin
                        ok_inc  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            S_DROP: begin
                mac_s_tready = 1'b1;
                if (mac_s_tvalid && mac_s_tlast) begin
                    drop_inc = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        ok_d   = (ok_inc   && ok_q   != 16'hFFFF) ? ok_q   + 16'd1 : ok_q;
        drop_d = (drop_inc && drop_q != 16'hFFFF) ? drop_q + 16'd1 : drop_q;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q      <= S_IDLE;
            w0_q         <= '0;
            w1_q         <= '0;
            en_q         <= 1'b0;
            lpe_q        <= 1'b0;
            run_q        <= 1'b0;
            mtbl_index_q <= '0;
            hbit_q       <= '0;
            lk_cnt_q     <= '0;
            match_q      <= 1'b0;
            rp_q         <= 1'b0;
            bytes_q      <= '0;
            ok_q         <= '0;
            drop_q       <= '0;
        end else begin
            state_q      <= state_d;
            w0_q         <= w0_d;
            w1_q         <= w1_d;
            en_q         <= en_d;
            lpe_q        <= lpe_d;
            run_q        <= run_d;
            mtbl_index_q <= mtbl_index_d;
            hbit_q       <= hbit_d;
            lk_cnt_q     <= lk_cnt_d;
            match_q      <= match_d;
            rp_q         <= rp_d;
            bytes_q      <= bytes_d;
            ok_q         <= ok_d;
            drop_q       <= drop_d;
        end
    end

endmodule
